// File: rtl/ghostbus_arbiter.sv
// Two-requester round-robin arbiter onto a single ghostbus with fixed read latency RD_LAT.
// Define GHOSTBUS_ARB_LOCK_EN to let a requester hold the grant via rN_lock.
module ghostbus_arbiter #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic          r0_lock,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    input  logic          r1_lock,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,

    output logic [AW-1:0] addr,
    output logic [DW-1:0] din,
    output logic          we,
    input  logic [DW-1:0] dout,
    output logic          grant
);

`ifdef GHOSTBUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_prio;
    logic        r_isWrite;
    logic [1:0]  r_waitCnt;
    logic        r_lockActive;
    logic        r_lockOwner;

    logic          w_lockHold;
    logic          w_elig0;
    logic          w_elig1;
    logic          w_winner;
    logic          w_winWe;
    logic [AW-1:0] w_winAddr;
    logic [DW-1:0] w_winWdata;
    logic          w_readDone;
    logic          w_finish;
    logic          w_grantLock;

    // A held lock masks the other requester; a lock that has dropped releases arbitration.
    assign w_lockHold = LOCK_EN && r_lockActive && (r_lockOwner ? r1_lock : r0_lock);
    assign w_elig0    = r0_req && !(w_lockHold && r_lockOwner);
    assign w_elig1    = r1_req && !(w_lockHold && !r_lockOwner);
    assign w_winner   = (w_elig0 && w_elig1) ? r_prio : w_elig1;
    assign w_winWe    = w_winner ? r1_we    : r0_we;
    assign w_winAddr  = w_winner ? r1_addr  : r0_addr;
    assign w_winWdata = w_winner ? r1_wdata : r0_wdata;
    assign w_grantLock = grant ? r1_lock : r0_lock;

    assign w_readDone = ((r_state == S_ISSUE) && !r_isWrite && (RD_LAT == 1)) ||
                        ((r_state == S_WAIT) && (r_waitCnt == 2'd0));
    assign w_finish   = w_readDone || ((r_state == S_ISSUE) && r_isWrite);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_isWrite    <= 1'b0;
            r_waitCnt    <= 2'd0;
            r_lockActive <= 1'b0;
            r_lockOwner  <= 1'b0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_rdata     <= '0;
            r1_rdata     <= '0;
            addr         <= '0;
            din          <= '0;
            we           <= 1'b0;
            grant        <= 1'b0;
        end else begin
            we     <= 1'b0;
            r0_ack <= w_finish && !grant;
            r1_ack <= w_finish && grant;

            if (w_readDone) begin
                if (grant) r1_rdata <= dout;
                else       r0_rdata <= dout;
            end

            // Bus address/data are driven at the grant edge so they are valid throughout ISSUE.
            case (r_state)
                S_IDLE: begin
                    if (r_lockActive && !w_lockHold) r_lockActive <= 1'b0;
                    if (w_elig0 || w_elig1) begin
                        grant     <= w_winner;
                        r_prio    <= ~w_winner;
                        r_isWrite <= w_winWe;
                        we        <= w_winWe;
                        addr      <= w_winAddr;
                        din       <= w_winWdata;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_finish) begin
                        r_state <= S_DONE;
                    end else begin
                        r_waitCnt <= 2'(RD_LAT - 2);
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_finish) r_state   <= S_DONE;
                    else          r_waitCnt <= r_waitCnt - 2'd1;
                end
                S_DONE: begin
                    r_lockActive <= LOCK_EN && w_grantLock;
                    r_lockOwner  <= grant;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghostbus_arbiter.sv
// Self-checking bench for ghostbus_arbiter: directed cases plus randomized traffic
// compared every cycle against a transaction-level timeline model.
module tb_ghostbus_arbiter;

    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int RD_LAT = 3;

`ifdef GHOSTBUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          r0_req, r0_we, r0_lock, r0_ack;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_req, r1_we, r1_lock, r1_ack;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          we;
    logic [DW-1:0] dout;
    logic          grant;

    int testCount = 0;
    int failCount = 0;
    bit doutRandom = 1'b0;
    logic [DW-1:0] doutFixed = 32'h42;
    int order[4];

    ghostbus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_lock(r0_lock), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_lock(r1_lock), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .addr(addr), .din(din), .we(we), .dout(dout), .grant(grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        dout = '0;
        forever begin
            @(posedge clk);
            #1;
            dout = doutRandom ? DW'($urandom) : doutFixed;
        end
    end

    // Reference model: each grant books a bus slot ending in an ack, followed by one idle cycle.
    int            edgeCnt, nextElig, pendAckEdge;
    bit            pendActive, pendWe, pendWho, prio, lockActive, lockOwner;
    logic          mWe, mGrant;
    logic [1:0]    mAck;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mDin;
    logic [DW-1:0] mRdata[2];

    always @(posedge clk or negedge rst_n) begin
        bit e0, e1, w, reqWe;
        bit lockv[2];
        if (!rst_n) begin
            edgeCnt = 0; nextElig = 0; pendAckEdge = 0;
            pendActive = 0; pendWe = 0; pendWho = 0; prio = 0;
            lockActive = 0; lockOwner = 0;
            mWe = 0; mGrant = 0; mAck = '0; mAddr = '0; mDin = '0;
            mRdata[0] = '0; mRdata[1] = '0;
        end else begin
            edgeCnt++;
            lockv[0] = r0_lock;
            lockv[1] = r1_lock;
            mWe  = 1'b0;
            mAck = 2'b00;
            if (pendActive && edgeCnt == pendAckEdge) begin
                mAck[pendWho] = 1'b1;
                if (!pendWe) mRdata[pendWho] = dout;
            end else if (pendActive && edgeCnt == pendAckEdge + 1) begin
                lockActive = LOCK_EN && lockv[pendWho];
                lockOwner  = pendWho;
                pendActive = 0;
                nextElig   = edgeCnt + 1;
            end
            if (!pendActive && edgeCnt >= nextElig) begin
                e0 = r0_req;
                e1 = r1_req;
                if (lockActive) begin
                    if (lockv[lockOwner]) begin
                        if (lockOwner) e0 = 0;
                        else           e1 = 0;
                    end else begin
                        lockActive = 0;
                    end
                end
                if (e0 || e1) begin
                    w      = (e0 && e1) ? prio : e1;
                    prio   = !w;
                    reqWe  = w ? r1_we : r0_we;
                    mGrant = w;
                    mWe    = reqWe;
                    mAddr  = w ? r1_addr : r0_addr;
                    mDin   = w ? r1_wdata : r0_wdata;
                    pendActive  = 1;
                    pendWho     = w;
                    pendWe      = reqWe;
                    pendAckEdge = edgeCnt + (reqWe ? 1 : RD_LAT);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_we",       64'(we),       64'(mWe));
        checkOutput("model_addr",     64'(addr),     64'(mAddr));
        checkOutput("model_din",      64'(din),      64'(mDin));
        checkOutput("model_r0_ack",   64'(r0_ack),   64'(mAck[0]));
        checkOutput("model_r1_ack",   64'(r1_ack),   64'(mAck[1]));
        checkOutput("model_grant",    64'(grant),    64'(mGrant));
        checkOutput("model_r0_rdata", 64'(r0_rdata), 64'(mRdata[0]));
        checkOutput("model_r1_rdata", 64'(r1_rdata), 64'(mRdata[1]));
    end

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic dropAll();
        r0_req = 0; r1_req = 0; r0_lock = 0; r1_lock = 0;
    endtask

    task automatic collectAcks(input bit dropLockAfter3, output int got);
        got = 0;
        for (int c = 0; c < 80 && got < 4; c++) begin
            @(negedge clk);
            if (r0_ack || r1_ack) begin
                order[got] = r1_ack ? 1 : 0;
                got++;
                if (dropLockAfter3 && got == 3) r1_lock = 1'b0;
            end
        end
    endtask

    // One cycle of random requester behaviour, including early drops and lock toggling.
    task automatic applyStimulus();
        if (r0_req && r0_ack)                   r0_req = 0;
        else if (r0_req && $urandom_range(0, 29) == 0) r0_req = 0;
        else if (!r0_req && $urandom_range(0, 2) == 0) begin
            r0_req = 1; r0_we = 1'($urandom_range(0, 1));
            r0_addr = AW'($urandom); r0_wdata = DW'($urandom);
        end
        if (r1_req && r1_ack)                   r1_req = 0;
        else if (r1_req && $urandom_range(0, 29) == 0) r1_req = 0;
        else if (!r1_req && $urandom_range(0, 2) == 0) begin
            r1_req = 1; r1_we = 1'($urandom_range(0, 1));
            r1_addr = AW'($urandom); r1_wdata = DW'($urandom);
        end
        if ($urandom_range(0, 5) == 0) r0_lock = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) r1_lock = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int got;
        int expRr[4];
        int expLock[4];
        expRr = '{0, 1, 0, 1};
        if (LOCK_EN) expLock = '{1, 1, 1, 0};
        else         expLock = '{1, 0, 1, 0};

        rst_n = 1'b0;
        r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0; r0_lock = 0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_lock = 0;
        resetDut();

        @(negedge clk);
        checkOutput("reset_we",    64'(we),    64'd0);
        checkOutput("reset_addr",  64'(addr),  64'd0);
        checkOutput("reset_grant", 64'(grant), 64'd0);

        // Single write from r0
        @(posedge clk); #1;
        r0_req = 1; r0_we = 1; r0_addr = 24'h40; r0_wdata = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        checkOutput("wr_we_high", 64'(we),     64'd1);
        checkOutput("wr_addr",    64'(addr),   64'h40);
        checkOutput("wr_din",     64'(din),    64'hA5);
        checkOutput("wr_ack_early", 64'(r0_ack), 64'd0);
        @(negedge clk);
        checkOutput("wr_we_low",  64'(we),     64'd0);
        checkOutput("wr_r0_ack",  64'(r0_ack), 64'd1);
        checkOutput("wr_r1_ack",  64'(r1_ack), 64'd0);
        @(posedge clk); #1;
        r0_req = 0;
        @(negedge clk);
        checkOutput("wr_ack_once", 64'(r0_ack), 64'd0);

        // Read from r1 with bus returning 0x42
        @(posedge clk); #1;
        r1_req = 1; r1_we = 0; r1_addr = 24'h123;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("rd_ack_timing", 64'(r1_ack), 64'(k == 3));
            checkOutput("rd_we_zero",    64'(we),     64'd0);
        end
        checkOutput("rd_rdata", 64'(r1_rdata), 64'h42);
        checkOutput("rd_grant", 64'(grant),    64'd1);
        @(posedge clk); #1;
        r1_req = 0;
        repeat (3) @(posedge clk);

        // Continuous contention alternates
        resetDut();
        @(posedge clk); #1;
        r0_req = 1; r0_we = 1; r0_addr = 24'h100; r0_wdata = 32'h1111;
        r1_req = 1; r1_we = 1; r1_addr = 24'h200; r1_wdata = 32'h2222;
        collectAcks(1'b0, got);
        checkOutput("rr_count", 64'(got), 64'd4);
        for (int i = 0; i < 4; i++) checkOutput("rr_order", 64'(order[i]), 64'(expRr[i]));
        @(posedge clk); #1;
        dropAll();
        repeat (6) @(posedge clk);

        // Reset during WAIT of a read aborts it
        resetDut();
        @(posedge clk); #1;
        r0_req = 1; r0_we = 0; r0_addr = 24'h55;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_we",    64'(we),       64'd0);
        checkOutput("abort_addr",  64'(addr),     64'd0);
        checkOutput("abort_din",   64'(din),      64'd0);
        checkOutput("abort_grant", 64'(grant),    64'd0);
        checkOutput("abort_ack",   64'(r0_ack),   64'd0);
        checkOutput("abort_rdata", 64'(r0_rdata), 64'd0);
        r0_req = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checkOutput("abort_no_ack", 64'(r0_ack), 64'd0);
        end
        @(posedge clk); #1;
        r0_req = 1; r0_we = 1; r0_addr = 24'h10; r0_wdata = 32'hAA;
        r1_req = 1; r1_we = 1; r1_addr = 24'h20; r1_wdata = 32'hBB;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (r0_ack || r1_ack) break;
        end
        checkOutput("post_reset_r0_first", 64'(r0_ack), 64'd1);
        checkOutput("post_reset_r1_wait",  64'(r1_ack), 64'd0);
        @(posedge clk); #1;
        dropAll();
        repeat (6) @(posedge clk);

        // Grant hold via r1_lock
        resetDut();
        @(posedge clk); #1;
        r1_req = 1; r1_we = 1; r1_lock = 1; r1_addr = 24'h300; r1_wdata = 32'h3333;
        @(posedge clk); #1;
        r0_req = 1; r0_we = 1; r0_addr = 24'h400; r0_wdata = 32'h4444;
        collectAcks(1'b1, got);
        checkOutput("lock_count", 64'(got), 64'd4);
        for (int i = 0; i < 4; i++) checkOutput("lock_order", 64'(order[i]), 64'(expLock[i]));
        @(posedge clk); #1;
        dropAll();
        repeat (6) @(posedge clk);

        // Randomized traffic with one asynchronous reset mid-run
        resetDut();
        doutRandom = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (i == 1500) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
                @(posedge clk); #1;
            end
            applyStimulus();
        end
        dropAll();
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ghostbus_arbiter.md
GHOSTBUS_ARBITER -- requirements
Module: ghostbus_arbiter

Interface
REQ-001 Parameter AW, default 24, bus address width.
REQ-002 Parameter DW, default 32, bus data width.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles from the bus strobe cycle to valid dout; legal range 1..4.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rN_req  in  1  requester N (N=0,1) transaction request; held high until rN_ack is seen.
REQ-007 rN_we  in  1  requester N: 1 = write, 0 = read; stable while rN_req is high.
REQ-008 rN_addr  in  AW  requester N address; stable while rN_req is high.
REQ-009 rN_wdata  in  DW  requester N write data; stable while rN_req is high.
REQ-010 rN_lock  in  1  requester N grant-hold request; used only per REQ-031.
REQ-011 rN_ack  out  1  one-cycle completion pulse to requester N.
REQ-012 rN_rdata  out  DW  requester N read data; valid in the rN_ack cycle, held until that requester's next read completes.
REQ-013 addr  out  AW  shared ghostbus address.
REQ-014 din  out  DW  shared ghostbus write data.
REQ-015 we  out  1  shared ghostbus write strobe; exactly one cycle per write.
REQ-016 dout  in  DW  shared ghostbus read data.
REQ-017 grant  out  1  index of the requester owning the current or most recent transaction.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE; all outputs registered.
REQ-019 IDLE: on a clock edge with any rN_req high, latch the winner's we/addr/wdata and grant, then go to ISSUE; otherwise remain in IDLE.
REQ-020 Arbitration SHALL be round-robin: the requester granted last has lower priority; after reset, r0 has priority.
REQ-021 ISSUE (one cycle): drive addr/din from the latch; we = latched we; next state is DONE for a write, WAIT for a read.
REQ-022 WAIT: count RD_LAT-1 cycles after ISSUE, then capture dout into rdata of the granted requester and go to DONE (RD_LAT=1 -> zero WAIT cycles; capture at the ISSUE->DONE edge).
REQ-023 DONE (one cycle): rN_ack=1 for the granted requester only; next state is unconditionally IDLE.
REQ-024 Write latency: req sampled at edge E -> we high in cycle E+1 -> ack high in cycle E+2.
REQ-025 Read latency: req sampled at edge E -> ack high in cycle E+2+(RD_LAT-1).
REQ-026 Outside ISSUE, we SHALL be 0; addr/din hold their last driven values.
REQ-027 A request dropped before ack SHALL still complete on the bus and produce its ack pulse.
REQ-028 Simultaneous requests: the loser waits in IDLE at most one transaction; no request is starved.
REQ-029 Minimum spacing: one IDLE cycle between DONE and the next ISSUE.

Reset
REQ-030 Asserting rst_n low at any time SHALL abort any transaction immediately: state IDLE; we, addr, din, r0_ack, r1_ack, r0_rdata, r1_rdata and grant are 0; round-robin pointer set to r0-priority. No ack is issued for the aborted transaction.

Configuration
REQ-031 With GHOSTBUS_ARB_LOCK_EN defined: if rN_lock of the granted requester is high when the DONE cycle's clock edge occurs, the next grant SHALL go only to that requester while its lock remains high (the other requester's req is ignored); without the macro, rN_lock is ignored and REQ-020 alone applies.

Verification
REQ-032 Write from r0 only (addr=0x40, wdata=0xA5, RD_LAT=1) -> one cycle we=1 with addr=0x40/din=0xA5, r0_ack one cycle later, r1_ack never.
REQ-033 Read from r1, RD_LAT=3, bus model returns 0x42 -> r1_ack at cycle E+4, r1_rdata=0x42, we stays 0.
REQ-034 r0 and r1 request together continuously, 4 transactions -> grant order 0,1,0,1.
REQ-035 rst_n pulsed low during WAIT of a read -> no ack, all outputs 0, next request served normally with r0 priority.
REQ-036 Macro defined, r1_lock=1 for 3 transactions with r0_req held -> 3 consecutive r1 grants, then r0; macro undefined -> alternation.
